difftest_arch_event_collector: RTL

Collects trap events (interrupts and exceptions) from the CSR/commit path and pairs each exception with its faulting instruction word, which arrives later and in order. It produces one fully populated architectural event per cycle for the difftest ArchEvent DPI sink. That sink samples its inputs every cycle, so all event fields read zero whenever no event is emitted. Exceptions wait for their instruction word; interrupts need none. Events leave in strict arrival order.

---
 rtl/difftest_arch_event_collector.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/difftest_arch_event_collector.sv
// Trap event collector: queues interrupts/exceptions in arrival order, pairs each
// exception with its later instruction word, and emits one registered event per cycle.
module difftest_arch_event_collector #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  io_coreid,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  input  logic        io_in_isInterrupt,
  input  logic [31:0] io_in_cause,
  input  logic [63:0] io_in_pc,
  input  logic        io_inst_valid,
  input  logic [31:0] io_inst_bits,
  output logic        io_out_valid,
  output logic [7:0]  io_out_coreid,
  output logic [31:0] io_out_intrNO,
  output logic [31:0] io_out_cause,
  output logic [63:0] io_out_exceptionPC,
  output logic [31:0] io_out_exceptionInst,
  output logic        io_overflow,
  output logic        io_instOrphan
);
  localparam int AW = $clog2(DEPTH);

  // Handshake: an event is taken on io_in_valid && io_in_ready; io_in_ready
  // depends only on the stored count, never on a same-cycle dequeue.

  logic          ent_intr  [DEPTH];
  logic [31:0]   ent_cause [DEPTH];
  logic [63:0]   ent_pc    [DEPTH];
  logic [31:0]   ent_inst  [DEPTH];
  logic          ent_done  [DEPTH];

  logic [AW-1:0] head, tail, fill;
  logic [AW:0]   count;
  logic          fill_found;

  logic          enq, enq_exc, fill_old, fill_new, orphan_now, deq;
  logic          hd_valid, hd_done, hd_intr;
  logic [31:0]   hd_cause, hd_inst;
  logic [63:0]   hd_pc;

  assign io_in_ready = (count < (AW+1)'(DEPTH)) && !reset;
  assign enq         = io_in_valid && io_in_ready;
  assign enq_exc     = enq && !io_in_isInterrupt;

  // fill: oldest stored entry still waiting for its instruction word
  always_comb begin
    fill       = head;
    fill_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!fill_found && ((AW+1)'(i) < count) && !ent_done[head + AW'(i)]) begin
        fill_found = 1'b1;
        fill       = head + AW'(i);
      end
    end
  end

  assign fill_old   = io_inst_valid && fill_found;
  assign fill_new   = io_inst_valid && !fill_found && enq_exc;
  assign orphan_now = io_inst_valid && !fill_found && !enq_exc;

  // Effective head includes a same-cycle enqueue into an empty FIFO and a
  // same-cycle fill of the stored head, so ready events leave without a bubble.
  always_comb begin
    hd_valid = 1'b0;
    hd_done  = 1'b0;
    hd_intr  = 1'b0;
    hd_cause = '0;
    hd_pc    = '0;
    hd_inst  = '0;
    if (count == '0) begin
      hd_valid = enq;
      hd_intr  = io_in_isInterrupt;
      hd_cause = io_in_cause;
      hd_pc    = io_in_pc;
      hd_inst  = fill_new ? io_inst_bits : 32'd0;
      hd_done  = io_in_isInterrupt || fill_new;
    end else begin
      hd_valid = 1'b1;
      hd_intr  = ent_intr[head];
      hd_cause = ent_cause[head];
      hd_pc    = ent_pc[head];
      if (fill_old && fill == head) begin
        hd_inst = io_inst_bits;
        hd_done = 1'b1;
      end else begin
        hd_inst = ent_inst[head];
        hd_done = ent_done[head];
      end
    end
  end

  assign deq = hd_valid && hd_done;

  always_ff @(posedge clock) begin
    if (reset) begin
      head                 <= '0;
      tail                 <= '0;
      count                <= '0;
      io_overflow          <= 1'b0;
      io_instOrphan        <= 1'b0;
      io_out_valid         <= 1'b0;
      io_out_coreid        <= '0;
      io_out_intrNO        <= '0;
      io_out_cause         <= '0;
      io_out_exceptionPC   <= '0;
      io_out_exceptionInst <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_intr[i]  <= 1'b0;
        ent_cause[i] <= '0;
        ent_pc[i]    <= '0;
        ent_inst[i]  <= '0;
        ent_done[i]  <= 1'b0;
      end
    end else begin
      if (enq) begin
        ent_intr[tail]  <= io_in_isInterrupt;
        ent_cause[tail] <= io_in_cause;
        ent_pc[tail]    <= io_in_pc;
        ent_inst[tail]  <= fill_new ? io_inst_bits : 32'd0;
        ent_done[tail]  <= io_in_isInterrupt || fill_new;
        tail            <= tail + 1'b1;
      end
      if (fill_old) begin
        ent_inst[fill] <= io_inst_bits;
        ent_done[fill] <= 1'b1;
      end
      if (deq) head <= head + 1'b1;
      count <= count + (AW+1)'(enq) - (AW+1)'(deq);

      if (io_in_valid && !io_in_ready) io_overflow <= 1'b1;
      if (orphan_now) io_instOrphan <= 1'b1;

      io_out_coreid        <= io_coreid;
      io_out_valid         <= deq;
      io_out_intrNO        <= (deq && hd_intr)  ? hd_cause : 32'd0;
      io_out_cause         <= (deq && !hd_intr) ? hd_cause : 32'd0;
      io_out_exceptionPC   <= deq ? hd_pc : 64'd0;
      io_out_exceptionInst <= (deq && !hd_intr) ? hd_inst : 32'd0;
    end
  end
endmodule
